// File: rtl/seg7_scan_controller_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_controller_if
//
// Processor data-bus slice seen by the seven-segment scanner. The CPU side
// (master) drives the address, store data and the load/store strobes. The
// scanner (slave) returns the combinational read-back word.
//
// Signals:
//   i_addr      [31:0]  bus byte address
//   i_WriteData [31:0]  store data
//   i_MemWrite          store strobe, sampled on the rising clock edge
//   i_MemRead           load strobe
//   o_ReadData  [31:0]  read-back data, 0 when the scanner is not selected
// ---------------------------------------------------------------------------
interface seg7_scan_controller_if;
   logic [31:0] i_addr;
   logic [31:0] i_WriteData;
   logic        i_MemWrite;
   logic        i_MemRead;
   logic [31:0] o_ReadData;

   modport master (
      output i_addr,
      output i_WriteData,
      output i_MemWrite,
      output i_MemRead,
      input  o_ReadData
   );

   modport slave (
      input  i_addr,
      input  i_WriteData,
      input  i_MemWrite,
      input  i_MemRead,
      output o_ReadData
   );
endinterface

// File: rtl/seg7_scan_controller.sv
// ---------------------------------------------------------------------------
// seg7_scan_controller
//
// Memory-mapped scanner for a 4-digit, common-anode seven-segment display.
// A single store to BASE_ADDR loads a 16-bit hex value, per-digit decimal
// points, an enable and a leading-zero-blanking flag. The block then lights
// one digit at a time, each for SCAN_DIV clock cycles, with registered pins.
//
// Parameters:
//   SCAN_DIV   clock cycles each digit stays lit (>= 1)
//   BASE_ADDR  byte address of the control/value register (word compare)
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   bus      data-bus slice (slave side): address, store data, strobes,
//            combinational read-back
//   o_an     digit anodes, active-low, bit n = digit n (digit 0 rightmost)
//   o_bcd7   segments, active-low, {dp,g,f,e,d,c,b,a}
//
// Register layout (store data / read-back):
//   [15:0] value   [19:16] dp_mask   [20] en   [21] lzb   [31:22] zero
// ---------------------------------------------------------------------------
module seg7_scan_controller #(
   parameter int          SCAN_DIV  = 100000,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
   input  logic                    clk,
   input  logic                    reset,
   seg7_scan_controller_if.slave   bus,
   output logic [3:0]              o_an,
   output logic [7:0]              o_bcd7
);

   localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [15:0]      value_q,   value_d;
   logic [3:0]       dp_mask_q, dp_mask_d;
   logic             en_q,      en_d;
   logic             lzb_q,     lzb_d;
   logic [DIV_W-1:0] div_q,     div_d;
   logic [1:0]       idx_q,     idx_d;
   logic [3:0]       an_q,      an_d;
   logic [7:0]       bcd7_q,    bcd7_d;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic sel;
   logic wr_en;

   assign sel   = (bus.i_addr[31:2] == BASE_ADDR[31:2]);
   assign wr_en = bus.i_MemWrite && sel;

   assign bus.o_ReadData = (bus.i_MemRead && sel)
                         ? {10'b0, lzb_q, en_q, dp_mask_q, value_q}
                         : 32'h0;

   // Byte-lane bits of the address and the reserved store bits carry no meaning.
   logic unused_bits;
   assign unused_bits = ^{bus.i_addr[1:0], bus.i_WriteData[31:22]};

   // ------------------------------------------------------------------
   // Per-digit nibble and leading-zero blank flags
   // ------------------------------------------------------------------
   logic [3:0] digit_nib   [4];
   logic [3:0] digit_blank;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         assign digit_nib[gi] = value_q[4*gi +: 4];
         if (gi == 0) begin : g_rightmost
            // The rightmost digit always shows, so a zero value reads "0".
            assign digit_blank[gi] = 1'b0;
         end else begin : g_upper
            assign digit_blank[gi] = lzb_q && (value_q[15:4*gi] == '0);
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      value_d   = value_q;
      dp_mask_d = dp_mask_q;
      en_d      = en_q;
      lzb_d     = lzb_q;
      div_d     = div_q;
      idx_d     = idx_q;
      an_d      = 4'hF;
      bcd7_d    = 8'hFF;

      if (wr_en) begin
         value_d   = bus.i_WriteData[15:0];
         dp_mask_d = bus.i_WriteData[19:16];
         en_d      = bus.i_WriteData[20];
         lzb_d     = bus.i_WriteData[21];
      end

      // The scan only runs while enabled before and after this edge. A
      // store that clears en zeroes the counters at once, and a store that
      // sets en leaves them at zero so digit 0 gets a full first period.
      // Re-writing en=1 while running keeps the scan position.
      if (!(en_q && en_d)) begin
         div_d = '0;
         idx_d = 2'd0;
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      // Pins are drawn from the register contents before this edge, hence
      // the one-edge lag between a store and the display.
      if (en_q && !digit_blank[idx_q]) begin
         an_d   = ~(4'b0001 << idx_q);
         bcd7_d = {~dp_mask_q[idx_q], hex_to_seg(digit_nib[idx_q])};
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         value_q   <= 16'h0;
         dp_mask_q <= 4'h0;
         en_q      <= 1'b0;
         lzb_q     <= 1'b0;
         div_q     <= '0;
         idx_q     <= 2'd0;
         an_q      <= 4'hF;
         bcd7_q    <= 8'hFF;
      end else begin
         value_q   <= value_d;
         dp_mask_q <= dp_mask_d;
         en_q      <= en_d;
         lzb_q     <= lzb_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         bcd7_q    <= bcd7_d;
      end
   end

   assign o_an   = an_q;
   assign o_bcd7 = bcd7_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_controller
//
// Scoreboard bench for seg7_scan_controller with SCAN_DIV = 4. The stimulus
// process issues bus stores/loads and pushes hand-derived expected pin and
// read-back values, tagged with the clock cycle they belong to, into a
// queue. A separate monitor samples the DUT on each falling edge and pops
// and compares every entry due in that cycle.
// ---------------------------------------------------------------------------
module tb_seg7_scan_controller;

   localparam logic [31:0] BASE = 32'h4000_0018;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] o_an;
   logic [7:0] o_bcd7;

   seg7_scan_controller_if bus_if ();

   seg7_scan_controller #(
      .SCAN_DIV  (4),
      .BASE_ADDR (BASE)
   ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus_if),
      .o_an   (o_an),
      .o_bcd7 (o_bcd7)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      bit          is_rd;
      int          ph;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   checks    = 0;
   int   errors    = 0;
   bit   stim_done = 1'b0;

   // Expected digit tables, packed {d3,d2,d1,d0}.
   localparam logic [15:0] AN_ALL  = 16'h7BDE;
   localparam logic [15:0] AN_LZB  = 16'hFFDE;
   localparam logic [31:0] BCD_B   = 32'hF9A4_B099;  // value 1234, no dp
   localparam logic [31:0] BCD_C   = 32'hFFFF_8840;  // value 00A0, dp0, lzb
   localparam logic [31:0] BCD_D1  = 32'h9282_F880;  // value 5678, no dp
   localparam logic [31:0] BCD_D2  = 32'h1282_7880;  // value 5678, dp1+dp3

   // Keep the scoreboard ordered by cycle.
   function automatic void push(exp_t e);
      int i;
      i = sb_q.size();
      while (i > 0 && sb_q[i-1].cyc > e.cyc) i--;
      sb_q.insert(i, e);
   endfunction

   task automatic exp_pins(int c, int ph, logic [3:0] an, logic [7:0] b);
      exp_t e;
      e.cyc = c; e.is_rd = 1'b0; e.ph = ph; e.exp = {20'h0, an, b};
      push(e);
   endtask

   task automatic exp_rd(int c, int ph, logic [31:0] d);
      exp_t e;
      e.cyc = c; e.is_rd = 1'b1; e.ph = ph; e.exp = d;
      push(e);
   endtask

   // Scan with period 4 started by an enabling store at edge phase0:
   // pins at edge c show digit ((c-1-phase0)/4) mod 4.
   task automatic exp_scan(int ph, int phase0, int c_from, int c_to,
                           logic [15:0] an_t, logic [31:0] b_t);
      for (int c = c_from; c <= c_to; c++) begin
         int d;
         d = ((c - 1 - phase0) / 4) % 4;
         exp_pins(c, ph, an_t[4*d +: 4], b_t[8*d +: 8]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(int c);
      while (cyc < c) tick();
   endtask

   // Presents a store for one cycle; e returns the edge that takes it.
   task automatic store(logic [31:0] a, logic [31:0] d, output int e);
      bus_if.i_addr      = a;
      bus_if.i_WriteData = d;
      bus_if.i_MemWrite  = 1'b1;
      tick();
      bus_if.i_MemWrite  = 1'b0;
      e = cyc;
      $display("store addr=%h data=%h at edge %0d", a, d, e);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int e1, e2, e3, e4, e5, e6, e7, r;

      reset              = 1'b1;
      bus_if.i_addr      = 32'h0;
      bus_if.i_WriteData = 32'h0;
      bus_if.i_MemWrite  = 1'b0;
      bus_if.i_MemRead   = 1'b0;

      // Reset and 20 idle cycles: dark display, read-back 0.
      for (int c = 1; c <= 22; c++) exp_pins(c, 0, 4'hF, 8'hFF);
      tick();
      tick();
      reset = 1'b0;
      wait_until(9);
      bus_if.i_addr    = BASE;
      bus_if.i_MemRead = 1'b1;
      exp_rd(9, 0, 32'h0);
      tick();
      bus_if.i_MemRead = 1'b0;
      wait_until(22);

      // Phase 1: value 1234 enabled; pins still dark on the store edge.
      store(BASE, 32'h0010_1234, e1);
      exp_pins(e1, 1, 4'hF, 8'hFF);
      exp_scan(1, e1, e1 + 1, e1 + 32, AN_ALL, BCD_B);
      bus_if.i_MemRead = 1'b1;
      exp_rd(e1, 1, 32'h0010_1234);
      tick();
      bus_if.i_MemRead = 1'b0;

      // Phase 2: new value stored on a divider terminal count while
      // running; scan position is kept, next digit uses the new value.
      wait_until(e1 + 31);
      store(BASE, 32'h0031_00A0, e2);
      exp_scan(2, e1, e2 + 1, e2 + 32, AN_LZB, BCD_C);
      bus_if.i_MemRead = 1'b1;
      exp_rd(e2, 2, 32'h0031_00A0);
      tick();
      bus_if.i_MemRead = 1'b0;

      // Phase 3: value 5678, then clear en during digit 2.
      wait_until(e1 + 63);
      store(BASE, 32'h0010_5678, e3);
      exp_scan(3, e1, e3 + 1, e1 + 74, AN_ALL, BCD_D1);
      wait_until(e1 + 73);
      store(BASE, 32'h0000_5678, e4);
      for (int c = e4 + 1; c <= e1 + 80; c++) exp_pins(c, 4, 4'hF, 8'hFF);

      // Phase 5: re-enable (reserved high bits set) -> digit 0 first, full.
      wait_until(e1 + 79);
      store(BASE, 32'hFFDA_5678, e5);
      exp_scan(5, e5, e5 + 1, e5 + 61, AN_ALL, BCD_D2);
      for (int c = e5 + 62; c <= e5 + 70; c++) exp_pins(c, 7, 4'hF, 8'hFF);
      bus_if.i_MemRead = 1'b1;
      exp_rd(e5, 5, 32'h001A_5678);
      tick();
      bus_if.i_MemRead = 1'b0;

      // Phase 6: stores to neighbouring addresses are ignored.
      wait_until(e5 + 15);
      store(BASE + 32'd4, 32'hFFFF_FFFF, e6);
      store(32'h4000_0010, 32'h0000_0000, e7);
      bus_if.i_addr    = BASE + 32'd4;
      bus_if.i_MemRead = 1'b1;
      exp_rd(e7, 6, 32'h0);
      tick();
      bus_if.i_addr    = BASE;
      bus_if.i_MemRead = 1'b0;
      exp_rd(cyc, 6, 32'h0);
      tick();
      bus_if.i_MemRead = 1'b1;
      exp_rd(cyc, 6, 32'h001A_5678);
      tick();
      bus_if.i_MemRead = 1'b0;

      // Phase 7: reset with a store presented while digit 3 is lit.
      r = e5 + 62;
      wait_until(r - 1);
      reset              = 1'b1;
      bus_if.i_addr      = BASE;
      bus_if.i_WriteData = 32'h0011_1234;
      bus_if.i_MemWrite  = 1'b1;
      tick();
      reset             = 1'b0;
      bus_if.i_MemWrite = 1'b0;
      bus_if.i_MemRead  = 1'b1;
      exp_rd(r, 7, 32'h0);
      $display("reset with store at edge %0d", r);
      tick();
      bus_if.i_MemRead = 1'b0;
      wait_until(e5 + 70);
      stim_done = 1'b1;
   end

   // ------------------------------------------------------------------
   // Monitor: compares every scoreboard entry due in the current cycle.
   // ------------------------------------------------------------------
   initial begin
      exp_t e;
      int   drain;
      drain = 0;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL sched ph%0d: entry for cycle %0d not checked (now cycle %0d)",
                        e.ph, e.cyc, cyc);
            end else if (e.is_rd) begin
               if (bus_if.o_ReadData !== e.exp) begin
                  errors++;
                  $display("FAIL readback ph%0d cyc %0d: got %h expected %h",
                           e.ph, cyc, bus_if.o_ReadData, e.exp);
               end
            end else begin
               if ({o_an, o_bcd7} !== e.exp[11:0]) begin
                  errors++;
                  $display("FAIL pins ph%0d cyc %0d: got an=%h bcd7=%h expected an=%h bcd7=%h",
                           e.ph, cyc, o_an, o_bcd7, e.exp[11:8], e.exp[7:0]);
               end
            end
         end
         if (stim_done) begin
            if (sb_q.size() == 0) break;
            drain++;
            if (drain > 200) begin
               errors++;
               $display("FAIL drain: %0d entries left after 200 cycles, expected 0",
                        sb_q.size());
               break;
            end
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
